// File: rtl/mem_ctrl_pkg.sv
// Shared size codes, FSM encoding and lane-alignment helpers for mem_access_ctrl.
// Optional macro MEM_CTRL_MISALIGN_TRAP_EN selects trap vs. force-align for misaligned requests.
package mem_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  // Size code 3 is reserved and behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: align_off = off;
      SZ_HALF: align_off = {off[1], 1'b0};
      default: align_off = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane extraction (with sign/zero extension) and lane insertion for RMW.
// Purely combinational; no latency, no flow control.
module byte_lane_merge
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] base_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [1:0] lane,
                                                input logic [1:0] sz,
                                                input logic sgn);
    logic [DATA_W-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] data,
                                              input logic [1:0] lane,
                                              input logic [1:0] sz);
    logic [DATA_W-1:0] mask;
    case (sz)
      SZ_BYTE: mask = 32'h0000_00FF << {lane, 3'b000};
      SZ_HALF: mask = 32'h0000_FFFF << {lane, 3'b000};
      default: mask = '1;
    endcase
    merge = (base & ~mask) | ((data << {lane, 3'b000}) & mask);
  endfunction

  assign load_data = extract(rd_word, off, size, sign_ext);
  assign merged    = merge(base_word, wdata, off, size);

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller for a single-port word RAM, with RMW for sub-word stores.
// Latency: load 2, word store 2, sub-word store 3 cycles; ready only in IDLE (1 req / 3 cycles).
// MEM_CTRL_MISALIGN_TRAP_EN: misaligned requests return err instead of being force-aligned.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              io_clk,
  input  logic              io_reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_we,
  input  logic [1:0]        io_req_size,
  input  logic              io_req_signed,
  input  logic [31:0]       io_req_addr,
  input  logic [31:0]       io_req_wdata,
  output logic              io_resp_valid,
  output logic [31:0]       io_resp_rdata,
  output logic              io_resp_err,
  output logic              io_ram_we,
  output logic [ADDR_W-1:0] io_ram_addra,
  output logic [31:0]       io_ram_dina,
  input  logic [31:0]       io_ram_douta
);

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                sgn_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;
  logic                accept;
  logic                unused_addr_hi;

  // Byte-address bits above the RAM window wrap.
  assign unused_addr_hi = ^io_req_addr[31:ADDR_W+2];

  assign accept = io_req_valid && (state_q == IDLE);

  byte_lane_merge u_lane (
    .rd_word   (io_ram_douta),
    .base_word (word_q),
    .wdata     (wdata_q),
    .off       (align_off(size_q, addr_q[1:0])),
    .size      (size_q),
    .sign_ext  (sgn_q),
    .load_data (load_data),
    .merged    (merged)
  );

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  logic mis_in;
  logic err_q;
  assign mis_in = is_misaligned(io_req_size, io_req_addr[1:0]);

  always_ff @(posedge io_clk) begin
    if (io_reset)    err_q <= 1'b0;
    else if (accept) err_q <= mis_in;
  end
  assign io_resp_err = err_q & io_resp_valid;
`else
  assign io_resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (io_req_valid) begin
          if (io_req_we && io_req_size != SZ_BYTE && io_req_size != SZ_HALF) state_d = WRITE;
          else                                                                state_d = READ;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
          if (mis_in) state_d = RESP;
`endif
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= io_req_addr[ADDR_W+1:0];
        size_q  <= io_req_size;
        we_q    <= io_req_we;
        sgn_q   <= io_req_signed;
        wdata_q <= io_req_wdata;
        rdata_q <= '0;
      end
      // RAM data for this cycle's address settles before the closing edge.
      if (state_q == READ) begin
        if (we_q) word_q  <= io_ram_douta;
        else      rdata_q <= load_data;
      end
    end
  end

  assign io_req_ready  = (state_q == IDLE);
  assign io_resp_valid = (state_q == RESP);
  assign io_resp_rdata = rdata_q;
  assign io_ram_we     = (state_q == WRITE);
  assign io_ram_addra  = addr_q[ADDR_W+1:2];
  assign io_ram_dina   = (state_q == WRITE) ? merged : '0;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the single-port word RAM wrapper (10-bit word address, 32-bit data, word-only write enable) on behalf of the multi-cycle CPU.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores.
- Returns aligned, zero- or sign-extended load data with a one-cycle response pulse.

Parameters:
- ADDR_W, 10, RAM word-address width; the byte address uses bits [ADDR_W+1:2].
- DATA_W, 32, RAM word width; fixed at 32 and not to be overridden.

Ports:
- io_clk  in  1  clock; all state updates on the rising edge.
- io_reset  in  1  synchronous, active-high reset.
- io_req_valid  in  1  CPU request present.
- io_req_ready  out  1  controller is in IDLE and can accept a request.
- io_req_we  in  1  1 = store, 0 = load.
- io_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- io_req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- io_req_addr  in  32  byte address; bits above ADDR_W+1 are ignored (wrap).
- io_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- io_resp_valid  out  1  one-cycle pulse: request complete.
- io_resp_rdata  out  32  extended load data; 0 for stores.
- io_resp_err  out  1  misaligned-access flag, qualified by io_resp_valid.
- io_ram_we  out  1  RAM write enable.
- io_ram_addra  out  ADDR_W  RAM word address.
- io_ram_dina  out  32  RAM write data.
- io_ram_douta  in  32  RAM read data.

Behaviour:
- Reset:
  - state = IDLE.
  - io_req_ready = 1 (it follows IDLE), io_resp_valid = 0, io_resp_err = 0, io_resp_rdata = 0.
  - io_ram_we = 0, io_ram_addra = 0, io_ram_dina = 0.
  - Reset mid-operation aborts the access; any write still pending is dropped.
- Handshake and capture:
  - A request is accepted on a rising edge where io_req_valid = 1 and state = IDLE.
  - addr, size, we, signed and wdata are registered at acceptance; request inputs are don't-care afterwards.
- RAM timing:
  - The RAM is clocked on the inverted clock, so io_ram_douta for the address driven in a cycle is valid by the end of that cycle.
  - The controller samples io_ram_douta on the rising edge that ends the READ state.
- Byte lanes are little-endian:
  - Byte lane b = addr[1:0] occupies bits [8b+7:8b].
  - Half lane h = addr[1] occupies bits [16h+15:16h].
- State machine:
  - IDLE -> READ on an accepted load, or on a store with size byte/half.
  - IDLE -> WRITE on an accepted word store.
  - READ (io_ram_we = 0, addra = word address):
    - load: capture the extracted and extended lane, -> RESP.
    - sub-word store: capture the word, -> WRITE.
  - WRITE (io_ram_we = 1 for exactly this cycle, addra = word address):
    - dina = wdata for a word store.
    - dina = the captured word with the target lane replaced by wdata[7:0] or wdata[15:0] for sub-word stores.
    - -> RESP.
  - RESP: io_resp_valid = 1 for one cycle, -> IDLE. io_req_ready returns to 1 in the following cycle.
- Latency from acceptance to io_resp_valid:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Back-to-back: a new request can be accepted in the cycle after RESP, so throughput is at most one request per 3 cycles.
- io_ram_we is 0 in every state except WRITE.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0. Handling is set by the Optional Feature.

Optional Feature:
- Macro: MEM_CTRL_MISALIGN_TRAP_EN.
- Defined: a misaligned request goes IDLE -> RESP directly.
  - io_resp_err = 1, io_resp_rdata = 0.
  - No RAM write ever occurs.
- Undefined:
  - Low address bits are forced to alignment: half uses addr[1]; word ignores addr[1:0].
  - io_resp_err is tied to 0.

Decomposition:
- Package mem_ctrl_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding IDLE/READ/WRITE/RESP;
  - DATA_W.
- Sub-module byte_lane_merge (purely combinational) contains two functions:
  - extract: lane select plus sign/zero extension;
  - merge: lane insertion for read-modify-write.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> RAM word 4 written once with io_ram_we high 1 cycle; load returns 0xDEADBEEF 2 cycles after acceptance.
- Byte store 0xA5 @0x11 over 0x11223344 -> RAM word = 0x1122A544; signed byte load @0x11 = 0xFFFFFFA5; unsigned = 0x000000A5.
- Half store 0x8001 @0x12 over 0x00000000 -> word = 0x80010000; signed half load @0x12 = 0xFFFF8001.
- Store with io_reset asserted in the READ cycle -> no io_ram_we pulse; RAM unchanged; io_req_ready = 1 the cycle after reset.
- io_req_valid held high for 3 requests -> each accepted only in IDLE; io_resp_valid pulses exactly 3 times; no request is lost or duplicated.
- Half load @0x13:
  - with MEM_CTRL_MISALIGN_TRAP_EN: io_resp_err = 1, rdata = 0, no RAM write;
  - without it: data from lane 1 (bits [31:16]), err = 0.
